// File: rtl/node_table_reader.sv
// node_table_reader: walks a contiguous range of the node bank and streams each word out over valid/ready.
// Define NODE_SKIP_EMPTY_EN to drop zero words (empty slots) instead of emitting them.
module node_table_reader #(
  parameter int WORD_WIDTH = 16,
  parameter int MEM_DEPTH  = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] mem_index,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, FINISH} state_t;
  localparam logic [ADDR_WIDTH:0]   CAP  = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE  = (ADDR_WIDTH+1)'(1);
  state_t state, state_nx;
  logic [ADDR_WIDTH:0]   remaining, remaining_nx, count_c;
  logic [ADDR_WIDTH-1:0] index_nx, out_index_nx, index_inc;
  logic [WORD_WIDTH-1:0] out_data_nx;
  logic                  last;
  assign count_c   = (count > CAP) ? CAP : count;
  assign index_inc = (mem_index == LAST) ? '0 : mem_index + 1'b1;
  assign last      = remaining == ONE;
  assign out_valid = state == EMIT;
  assign busy      = state != IDLE;
  assign done      = state == FINISH;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state     <= IDLE;
      remaining <= '0;
      mem_index <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      mem_index <= index_nx;
      out_data  <= out_data_nx;
      out_index <= out_index_nx;
    end
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    index_nx     = mem_index;
    out_data_nx  = out_data;
    out_index_nx = out_index;
    case (state)
      IDLE:
        if (start) begin
          index_nx     = base;
          remaining_nx = count_c;
          state_nx     = (count == '0) ? FINISH : FETCH;
        end
      FETCH:
`ifdef NODE_SKIP_EMPTY_EN
        if (mem_data == '0) begin
          remaining_nx = remaining - 1'b1;
          state_nx     = last ? FINISH : FETCH;
          index_nx     = last ? mem_index : index_inc;
        end else
`endif
        begin
          out_data_nx  = mem_data;
          out_index_nx = mem_index;
          state_nx     = EMIT;
        end
      EMIT:
        if (out_ready) begin
          remaining_nx = remaining - 1'b1;
          state_nx     = last ? FINISH : FETCH;
          index_nx     = last ? mem_index : index_inc;
        end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_node_table_reader.sv
// tb_node_table_reader: directed scenario tests for node_table_reader against a combinational bank model.
module tb_node_table_reader;
  logic        clk, nrst, start, out_ready, out_valid, busy, done;
  logic [5:0]  base, mem_index, out_index;
  logic [6:0]  count;
  logic [15:0] mem_data, out_data;
  logic [15:0] bank [64];
  int pass_cnt, total_cnt;
  int got_idx[$], got_data[$], got_cyc[$];
  int done_cyc, overlap, busy_gap;

  node_table_reader dut (
    .clk(clk), .nrst(nrst), .start(start), .base(base), .count(count),
    .mem_index(mem_index), .mem_data(mem_data), .out_data(out_data),
    .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  assign mem_data = bank[mem_index];
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scan with out_ready high; cycle 1 is the first cycle after the start edge.
  task automatic scan(input logic [5:0] b, input logic [6:0] n, input bit poke);
    got_idx.delete(); got_data.delete(); got_cyc.delete();
    done_cyc = -1; overlap = 0; busy_gap = 0;
    @(negedge clk);
    base = b; count = n; start = 1; out_ready = 1;
    tick();
    start = 0; base = 0; count = 0;
    for (int c = 1; c < 300; c++) begin
      if (poke) begin
        start = (c == 1 || c == 2);
        base = 62; count = 4;
      end
      if (out_valid && done) overlap++;
      if (!busy) busy_gap++;
      if (out_valid) begin
        got_idx.push_back(int'(out_index));
        got_data.push_back(int'(out_data));
        got_cyc.push_back(c);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    start = 0; base = 0; count = 0;
  endtask

  task automatic check_scan(input string name, input int exp_idx[], input int exp_data[],
                            input int exp_cyc[], input int exp_done);
    total_cnt++;
    if (got_idx.size() !== exp_idx.size())
      $display("FAIL %s emit count: got %0d want %0d", name, got_idx.size(), exp_idx.size());
    else pass_cnt++;
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      total_cnt++;
      if (got_idx[i] !== exp_idx[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i])
        $display("FAIL %s emit %0d: got idx=%0d data=%0d cyc=%0d want idx=%0d data=%0d cyc=%0d",
                 name, i, got_idx[i], got_data[i], got_cyc[i], exp_idx[i], exp_data[i], exp_cyc[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cyc !== exp_done) $display("FAIL %s done cycle: got %0d want %0d", name, done_cyc, exp_done);
    else pass_cnt++;
    total_cnt++;
    if (overlap !== 0 || busy_gap !== 0)
      $display("FAIL %s done/valid overlap=%0d busy gaps=%0d want 0/0", name, overlap, busy_gap);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    nrst = 0; start = 0; base = 0; count = 0; out_ready = 0;
    tick(); tick();
    total_cnt++;
    if ({mem_index, out_data, out_index, out_valid, busy, done} !== '0)
      $display("FAIL reset values: got idx=%0d data=%0d oidx=%0d v=%b busy=%b done=%b want all 0",
               mem_index, out_data, out_index, out_valid, busy, done);
    else pass_cnt++;
    nrst = 1;
    tick();
  endtask

  task automatic test_basic();
`ifdef NODE_SKIP_EMPTY_EN
    scan(6'd0, 7'd3, 0);
    check_scan("skip_empty", '{0, 2}, '{3, 15}, '{2, 5}, 6);
`else
    scan(6'd0, 7'd3, 0);
    check_scan("basic", '{0, 1, 2}, '{3, 0, 15}, '{2, 4, 6}, 7);
`endif
  endtask

  task automatic test_wrap();
    bank[1] = 16'h0011;
    scan(6'd62, 7'd4, 0);
    check_scan("wrap", '{62, 63, 0, 1}, '{16'hA062, 16'hA063, 3, 16'h0011}, '{2, 4, 6, 8}, 9);
    bank[1] = 16'h0000;
  endtask

  task automatic test_start_while_busy();
`ifdef NODE_SKIP_EMPTY_EN
    scan(6'd0, 7'd3, 1);
    check_scan("busy_start", '{0, 2}, '{3, 15}, '{2, 5}, 6);
`else
    scan(6'd0, 7'd3, 1);
    check_scan("busy_start", '{0, 1, 2}, '{3, 0, 15}, '{2, 4, 6}, 7);
`endif
    tick();
    total_cnt++;
    if (busy !== 0 || out_valid !== 0) $display("FAIL busy_start idle after: busy=%b valid=%b want 0/0", busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_count_zero();
    @(negedge clk);
    base = 6'd5; count = 7'd0; start = 1;
    tick();
    start = 0;
    total_cnt++;
    if (done !== 1 || out_valid !== 0) $display("FAIL count0 t+1: done=%b valid=%b want 1/0", done, out_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 0 || busy !== 0 || out_valid !== 0)
      $display("FAIL count0 t+2: done=%b busy=%b valid=%b want 0/0/0", done, busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 64; i++) bank[i] = 16'h8000 | 16'(i);
    scan(6'd10, 7'd100, 0);
    total_cnt++;
    if (got_idx.size() !== 64 || done_cyc !== 129)
      $display("FAIL clamp: got %0d emits done at %0d want 64 emits done at 129", got_idx.size(), done_cyc);
    else pass_cnt++;
    total_cnt++;
    if (got_idx.size() == 64 && (got_idx[53] !== 63 || got_idx[54] !== 0 || got_data[63] !== 16'h8009))
      $display("FAIL clamp order: got idx53=%0d idx54=%0d data63=%0d want 63/0/%0d",
               got_idx[53], got_idx[54], got_data[63], 16'h8009);
    else pass_cnt++;
    init_bank();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    base = 6'd4; count = 7'd1; start = 1; out_ready = 0;
    tick();
    start = 0;
    total_cnt++;
    if (busy !== 1 || mem_index !== 6'd4 || out_valid !== 0)
      $display("FAIL bp t+1: busy=%b idx=%0d valid=%b want 1/4/0", busy, mem_index, out_valid);
    else pass_cnt++;
    tick();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (out_valid !== 1 || out_data !== 16'd45 || out_index !== 6'd4 || mem_index !== 6'd4 || done !== 0)
        $display("FAIL bp stall %0d: valid=%b data=%0d oidx=%0d idx=%0d done=%b want 1/45/4/4/0",
                 i, out_valid, out_data, out_index, mem_index, done);
      else pass_cnt++;
      tick();
    end
    out_ready = 1;
    tick();
    total_cnt++;
    if (done !== 1 || out_valid !== 0) $display("FAIL bp release: done=%b valid=%b want 1/0", done, out_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 0 || busy !== 0) $display("FAIL bp idle: done=%b busy=%b want 0/0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_emit();
    int seen;
    @(negedge clk);
    base = 6'd4; count = 7'd3; start = 1; out_ready = 0;
    tick();
    start = 0;
    tick();
    total_cnt++;
    if (out_valid !== 1) $display("FAIL rst_mid setup: valid=%b want 1", out_valid);
    else pass_cnt++;
    nrst = 0;
    #1;
    total_cnt++;
    if ({mem_index, out_data, out_index, out_valid, busy, done} !== '0)
      $display("FAIL rst_mid async: idx=%0d data=%0d oidx=%0d v=%b busy=%b done=%b want all 0",
               mem_index, out_data, out_index, out_valid, busy, done);
    else pass_cnt++;
    out_ready = 1;
    @(negedge clk);
    nrst = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || out_valid || busy) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_mid after release: %0d active cycles want 0", seen);
    else pass_cnt++;
  endtask

  task automatic init_bank();
    for (int i = 0; i < 64; i++) bank[i] = 16'h0;
    bank[0] = 16'd3; bank[2] = 16'd15; bank[4] = 16'd45;
    bank[62] = 16'hA062; bank[63] = 16'hA063;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    init_bank();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_start_while_busy();
    test_clamp();
    test_reset_mid_emit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
